// File: rtl/measure_sampler_if.sv
// rtl/measure_sampler_if.sv - request/result bundle between a measurement requester and measure_sampler
//
// Ports (master drives requests, slave returns results):
//   start      measurement request, honoured only while the sampler is idle
//   rand_word  32-bit PRNG word; only its top PW bits are used, at acceptance
//   prob_flat  N*PW probabilities, basis state i at bits [i*PW +: PW]
//   busy       high from the cycle after acceptance through the done cycle
//   done       one-cycle pulse; outcome/fallthru valid from this cycle on
//   outcome    measured basis-state index
//   fallthru   cumulative sum never exceeded the draw; outcome forced to N-1

interface measure_sampler_if #(
    parameter int NQ = 2,
    parameter int PW = 16
);
    localparam int N = 1 << NQ;

    logic              start;
    logic [31:0]       rand_word;
    logic [N*PW-1:0]   prob_flat;
    logic              busy;
    logic              done;
    logic [NQ-1:0]     outcome;
    logic              fallthru;

    modport master (
        output start, rand_word, prob_flat,
        input  busy, done, outcome, fallthru
    );

    modport slave (
        input  start, rand_word, prob_flat,
        output busy, done, outcome, fallthru
    );
endinterface

// File: rtl/measure_sampler.sv
// rtl/measure_sampler.sv - projective-measurement sampler walking a cumulative distribution
//
// Turns a PRNG draw into a basis-state index over an NQ-qubit register by
// scanning a snapshot of the probability vector one state per clock and
// stopping at the first state whose cumulative probability exceeds the draw.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   ms     measure_sampler_if slave: start/rand_word/prob_flat in,
//          busy/done/outcome/fallthru out

module measure_sampler #(
    parameter int NQ = 2,
    parameter int PW = 16
) (
    input  logic              clk,
    input  logic              reset,
    measure_sampler_if.slave  ms
);
    localparam int            N       = 1 << NQ;
    localparam logic [NQ-1:0] IDX_MAX = NQ'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NQ-1:0]   idx_q, idx_d;
    logic [PW:0]     acc_q, acc_d;
    logic [PW-1:0]   r_q, r_d;
    logic [PW-1:0]   prob_q [N];
    logic [PW-1:0]   prob_d [N];
    logic [NQ-1:0]   outcome_q, outcome_d;
    logic            fallthru_q, fallthru_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    // Scan datapath: one extra bit on the accumulator keeps a full 2^PW sum
    // representable.
    logic [PW-1:0]   p_cur;
    logic [PW:0]     acc_next;
    logic            hit;
    logic            last;

    always_comb begin
        p_cur    = prob_q[idx_q];
        acc_next = acc_q + {1'b0, p_cur};
        // Strict compare: a draw equal to a cumulative boundary belongs to
        // the next state, and zero-probability states can never be hit.
        hit      = ({1'b0, r_q} < acc_next);
        last     = (idx_q == IDX_MAX);
    end

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            r_q        <= '0;
            outcome_q  <= '0;
            fallthru_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                prob_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            r_q        <= r_d;
            outcome_q  <= outcome_d;
            fallthru_q <= fallthru_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            for (int i = 0; i < N; i++) begin
                prob_q[i] <= prob_d[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ms.start) state_d = S_SCAN;
            S_SCAN:  if (hit || last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath / output logic.
    always_comb begin
        idx_d      = idx_q;
        acc_d      = acc_q;
        r_d        = r_q;
        outcome_d  = outcome_q;
        fallthru_d = fallthru_q;
        done_d     = 1'b0;
        for (int i = 0; i < N; i++) begin
            prob_d[i] = prob_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (ms.start) begin
                    // Draw and distribution are frozen here so that later
                    // changes on the inputs cannot disturb this measurement.
                    r_d   = ms.rand_word[31 -: PW];
                    acc_d = '0;
                    idx_d = '0;
                    for (int i = 0; i < N; i++) begin
                        prob_d[i] = ms.prob_flat[i*PW +: PW];
                    end
                end
            end
            S_SCAN: begin
                if (hit) begin
                    outcome_d  = idx_q;
                    fallthru_d = 1'b0;
                    done_d     = 1'b1;
                end else if (last) begin
                    // Deficient distribution: the draw lies beyond the total
                    // mass, so report the last state and flag it.
                    outcome_d  = IDX_MAX;
                    fallthru_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    acc_d = acc_next;
                    idx_d = idx_q + NQ'(1);
                end
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign ms.busy     = busy_q;
    assign ms.done     = done_q;
    assign ms.outcome  = outcome_q;
    assign ms.fallthru = fallthru_q;

endmodule

// File: tb/tb_measure_sampler.sv
// tb/tb_measure_sampler.sv - directed and scoreboard-driven bench for measure_sampler

module tb_measure_sampler;
    localparam int NQ = 2;
    localparam int PW = 16;
    localparam int N  = 1 << NQ;

    typedef struct {
        logic [NQ-1:0] outcome;
        logic          fallthru;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    measure_sampler_if #(.NQ(NQ), .PW(PW)) ms ();

    measure_sampler #(.NQ(NQ), .PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .ms    (ms)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*PW-1:0] pack4(input logic [15:0] p0, input logic [15:0] p1,
                                              input logic [15:0] p2, input logic [15:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    // Reference: first state whose running sum strictly exceeds the draw.
    function automatic exp_t model(input logic [N*PW-1:0] pf, input logic [31:0] rw);
        exp_t        e;
        int unsigned sum;
        int unsigned r;
        logic        found;
        sum        = 0;
        r          = int'(rw[31:16]);
        found      = 1'b0;
        e.outcome  = NQ'(N - 1);
        e.fallthru = 1'b1;
        e.lat      = N;
        for (int i = 0; i < N; i++) begin
            sum += int'(pf[i*PW +: PW]);
            if (!found && r < sum) begin
                found      = 1'b1;
                e.outcome  = NQ'(i);
                e.fallthru = 1'b0;
                e.lat      = i + 1;
            end
        end
        return e;
    endfunction

    task automatic measure(input string tag, input logic [N*PW-1:0] pf, input logic [31:0] rw);
        exp_t e;
        int   lat;
        lat = 0;
        @(negedge clk);
        ms.start     = 1'b1;
        ms.rand_word = rw;
        ms.prob_flat = pf;
        sb.push_back(model(pf, rw));
        @(negedge clk);
        // Scrambling inputs during the scan must not affect the result.
        ms.start     = 1'b0;
        ms.prob_flat = ~pf;
        ms.rand_word = ~rw;
        check({tag, " busy_after_accept"}, 32'(ms.busy), 32'd1);
        check({tag, " done_early"}, 32'(ms.done), 32'd0);
        for (int j = 1; j <= N + 1 && lat == 0; j++) begin
            @(negedge clk);
            if (ms.done === 1'b1) lat = j;
        end
        if (lat == 0) begin
            check({tag, " done_timeout"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check({tag, " latency"}, 32'(lat), 32'(e.lat));
            check({tag, " outcome"}, 32'(ms.outcome), 32'(e.outcome));
            check({tag, " fallthru"}, 32'(ms.fallthru), 32'(e.fallthru));
            check({tag, " busy_in_done"}, 32'(ms.busy), 32'd1);
            @(negedge clk);
            check({tag, " done_pulse_width"}, 32'(ms.done), 32'd0);
            check({tag, " busy_idle"}, 32'(ms.busy), 32'd0);
            check({tag, " outcome_hold"}, 32'(ms.outcome), 32'(e.outcome));
        end
    endtask

    logic [N*PW-1:0] tables [4];

    initial begin
        int   next_acc;
        int   done_obs;
        int   accepted;
        int   completed;
        int   cyc;
        exp_t e;
        logic [31:0] rw;
        logic [N*PW-1:0] pf;

        tables[0] = pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000);
        tables[1] = pack4(16'h1000, 16'h0000, 16'h0000, 16'h0000);
        tables[2] = pack4(16'h0000, 16'h8000, 16'h0000, 16'h8000);
        tables[3] = pack4(16'h0100, 16'h0200, 16'h7000, 16'h8D00);

        reset        = 1'b0;
        ms.start     = 1'b0;
        ms.rand_word = '0;
        ms.prob_flat = '0;
        #12;
        check("reset busy", 32'(ms.busy), 32'd0);
        check("reset done", 32'(ms.done), 32'd0);
        check("reset outcome", 32'(ms.outcome), 32'd0);
        check("reset fallthru", 32'(ms.fallthru), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases, including expected values stated outright.
        measure("uniform_left", tables[0], 32'h1A2B3C4D);
        check("uniform_left outcome_const", 32'(ms.outcome), 32'd0);
        measure("uniform_boundary", tables[0], 32'hC0000000);
        check("uniform_boundary outcome_const", 32'(ms.outcome), 32'd3);
        check("uniform_boundary fallthru_const", 32'(ms.fallthru), 32'd0);
        measure("deficient", tables[1], 32'h80000000);
        check("deficient outcome_const", 32'(ms.outcome), 32'd3);
        check("deficient fallthru_const", 32'(ms.fallthru), 32'd1);
        measure("zero_skip", tables[2], 32'h00000000);
        check("zero_skip outcome_const", 32'(ms.outcome), 32'd1);
        measure("skewed_mid", tables[3], 32'h05000000);
        measure("skewed_last", tables[3], 32'hFFFFFFFF);

        // start held high, rand and prob changing every cycle. At negedge c
        // we see the result of edge c-1; acceptance happens at edge c.
        next_acc  = 0;
        done_obs  = -1;
        accepted  = 0;
        completed = 0;
        cyc       = 0;
        while (completed < 10 && cyc < 400) begin
            @(negedge clk);
            if (cyc == done_obs) begin
                check("hold_start done", 32'(ms.done), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("hold_start outcome", 32'(ms.outcome), 32'(e.outcome));
                    check("hold_start fallthru", 32'(ms.fallthru), 32'(e.fallthru));
                end
                completed++;
            end else begin
                check("hold_start no_done", 32'(ms.done), 32'd0);
            end
            rw = $urandom;
            pf = tables[$urandom_range(0, 3)];
            ms.rand_word = rw;
            ms.prob_flat = pf;
            ms.start     = (accepted < 10) ? 1'b1 : 1'b0;
            if (cyc == next_acc && accepted < 10) begin
                e = model(pf, rw);
                sb.push_back(e);
                accepted++;
                done_obs = cyc + e.lat + 1;
                next_acc = cyc + e.lat + 2;
            end
            cyc++;
        end
        if (completed < 10) check("hold_start timeout", 32'd0, 32'd1);
        ms.start = 1'b0;
        sb.delete();
        @(negedge clk);
        check("hold_start idle_after", 32'(ms.busy), 32'd0);

        // Leave a nonzero outcome so the reset clear is visible.
        measure("pre_reset", tables[0], 32'hFFFFFFFF);

        // Abort mid-scan at idx=1.
        @(negedge clk);
        ms.start     = 1'b1;
        ms.rand_word = 32'h80000000;
        ms.prob_flat = tables[1];
        @(negedge clk);
        ms.start = 1'b0;
        @(negedge clk);
        check("abort busy_before", 32'(ms.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort busy", 32'(ms.busy), 32'd0);
        check("abort done", 32'(ms.done), 32'd0);
        check("abort outcome", 32'(ms.outcome), 32'd0);
        check("abort fallthru", 32'(ms.fallthru), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post_reset no_done", 32'(ms.done), 32'd0);
            check("post_reset no_busy", 32'(ms.busy), 32'd0);
        end

        measure("after_reset", tables[2], 32'h90000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
